// File: rtl/top_soc.sv
// Single-cycle RV32I-subset system: core, 64-word instruction ROM and 64-word data RAM.
// One instruction retires per rising edge; the data-memory bus is exported for observation only.

module imem (
  input  logic [5:0]  addr,
  output logic [31:0] instr
);
  logic [31:0] ROM [64];

  assign instr = ROM[addr];
endmodule

module dmem (
  input  logic        clk,
  input  logic        we,
  input  logic [5:0]  addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata
);
  logic [31:0] RAM [64];

  always_ff @(posedge clk) begin
    if (we) RAM[addr] <= wdata;
  end

  assign rdata = RAM[addr];
endmodule

module top_soc (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] data_to_mem,
  output logic [31:0] address_to_mem,
  output logic        write_enable
);
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  logic [31:0] pc, next_pc, pc_plus4, instr, read_data;
  logic [31:0] regs [32];
  logic [31:0] rs1_val, rs2_val, alu, wb_data, sra_val;
  logic [31:0] imm_i, imm_s, imm_b, imm_j, imm_u;
  logic [4:0]  rd, rs1, rs2, shamt;
  logic [2:0]  funct3;
  logic        alt, reg_we, mem_we, is_load, is_link, taken;

  imem imem (.addr(pc[7:2]), .instr(instr));
  dmem dmem (.clk(clk), .we(write_enable), .addr(address_to_mem[7:2]),
             .wdata(data_to_mem), .rdata(read_data));

  assign rd     = instr[11:7];
  assign rs1    = instr[19:15];
  assign rs2    = instr[24:20];
  assign funct3 = instr[14:12];
  assign alt    = instr[30];

  assign imm_i = {{20{instr[31]}}, instr[31:20]};
  assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
  assign imm_u = {instr[31:12], 12'd0};

  assign rs1_val  = (rs1 == 5'd0) ? 32'd0 : regs[rs1];
  assign rs2_val  = (rs2 == 5'd0) ? 32'd0 : regs[rs2];
  assign shamt    = rs2_val[4:0];
  assign sra_val  = $signed(rs1_val) >>> shamt;
  assign pc_plus4 = pc + 32'd4;

  always_comb begin
    alu     = rs1_val + imm_i;
    next_pc = pc_plus4;
    reg_we  = 1'b0;
    mem_we  = 1'b0;
    is_load = 1'b0;
    is_link = 1'b0;
    taken   = 1'b0;
    case (instr[6:0])
      OP_R: begin
        reg_we = 1'b1;
        case (funct3)
          3'b000:  alu = alt ? rs1_val - rs2_val : rs1_val + rs2_val;
          3'b001:  alu = rs1_val << shamt;
          3'b010:  alu = {31'd0, $signed(rs1_val) < $signed(rs2_val)};
          3'b100:  alu = rs1_val ^ rs2_val;
          3'b101:  alu = alt ? sra_val : rs1_val >> shamt;
          3'b110:  alu = rs1_val | rs2_val;
          3'b111:  alu = rs1_val & rs2_val;
          default: reg_we = 1'b0;
        endcase
      end
      OP_I: begin
        reg_we = 1'b1;
        case (funct3)
          3'b000:  alu = rs1_val + imm_i;
          3'b010:  alu = {31'd0, $signed(rs1_val) < $signed(imm_i)};
          3'b110:  alu = rs1_val | imm_i;
          3'b111:  alu = rs1_val & imm_i;
          default: reg_we = 1'b0;
        endcase
      end
      OP_LOAD: begin
        reg_we  = (funct3 == 3'b010);
        is_load = 1'b1;
      end
      OP_STORE: begin
        alu    = rs1_val + imm_s;
        mem_we = (funct3 == 3'b010);
      end
      OP_BRANCH: begin
        alu = rs1_val - rs2_val;
        case (funct3)
          3'b000:  taken = (rs1_val == rs2_val);
          3'b001:  taken = (rs1_val != rs2_val);
          3'b100:  taken = ($signed(rs1_val) < $signed(rs2_val));
          default: taken = 1'b0;
        endcase
        if (taken) next_pc = pc + imm_b;
      end
      OP_LUI: begin
        alu    = imm_u;
        reg_we = 1'b1;
      end
      OP_AUIPC: begin
        alu    = pc + imm_u;
        reg_we = 1'b1;
      end
      OP_JAL: begin
        alu     = pc + imm_j;
        reg_we  = 1'b1;
        is_link = 1'b1;
        next_pc = alu;
      end
      OP_JALR: begin
        if (funct3 == 3'b000) begin
          reg_we  = 1'b1;
          is_link = 1'b1;
          next_pc = {alu[31:1], 1'b0};
        end
      end
      default: ;
    endcase
  end

  assign wb_data        = is_load ? read_data : (is_link ? pc_plus4 : alu);
  assign address_to_mem = alu;
  assign data_to_mem    = rs2_val;
  assign write_enable   = mem_we & ~reset;

  // regs[0] is cleared by reset and never written, but reads of x0 bypass it anyway
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) regs[i] <= 32'd0;
    end else if (reg_we && rd != 5'd0) begin
      regs[rd] <= wb_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) pc <= 32'd0;
    else       pc <= next_pc;
  end
endmodule

// File: tb/tb_top_soc.sv
// Bench for top_soc: an instruction-level model runs each program ahead of the DUT and
// queues the stores it expects; a monitor pops and compares every store the DUT issues.

module tb_top_soc;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] data_to_mem, address_to_mem;
  logic        write_enable;

  top_soc dut (
    .clk(clk), .reset(reset), .data_to_mem(data_to_mem),
    .address_to_mem(address_to_mem), .write_enable(write_enable)
  );

  always #5 clk = ~clk;

  typedef enum {ADD, SUB, AND, OR, XOR, SLT, SLL, SRL, SRA, ADDI, ANDI, ORI, SLTI,
                LW, SW, BEQ, BNE, BLT, LUI, AUIPC, JAL, JALR, BAD} kind_t;
  typedef struct {
    kind_t       op;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
  } ins_t;
  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } store_t;

  int errors = 0;
  int checks = 0;
  store_t exp_q[$];
  ins_t prog [64];
  int plen;
  logic [31:0] m_regs [32];
  logic [31:0] m_ram [64];
  logic [31:0] m_pc;

  kind_t rops [9] = '{ADD, SUB, AND, OR, XOR, SLT, SLL, SRL, SRA};
  kind_t iops [4] = '{ADDI, ANDI, ORI, SLTI};
  kind_t bops [3] = '{BEQ, BNE, BLT};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] enc(input ins_t x);
    logic [31:0] im;
    im = x.imm;
    case (x.op)
      ADD:   return {7'b0000000, x.rs2, x.rs1, 3'd0, x.rd, 7'b0110011};
      SUB:   return {7'b0100000, x.rs2, x.rs1, 3'd0, x.rd, 7'b0110011};
      SLL:   return {7'b0000000, x.rs2, x.rs1, 3'd1, x.rd, 7'b0110011};
      SLT:   return {7'b0000000, x.rs2, x.rs1, 3'd2, x.rd, 7'b0110011};
      XOR:   return {7'b0000000, x.rs2, x.rs1, 3'd4, x.rd, 7'b0110011};
      SRL:   return {7'b0000000, x.rs2, x.rs1, 3'd5, x.rd, 7'b0110011};
      SRA:   return {7'b0100000, x.rs2, x.rs1, 3'd5, x.rd, 7'b0110011};
      OR:    return {7'b0000000, x.rs2, x.rs1, 3'd6, x.rd, 7'b0110011};
      AND:   return {7'b0000000, x.rs2, x.rs1, 3'd7, x.rd, 7'b0110011};
      ADDI:  return {im[11:0], x.rs1, 3'd0, x.rd, 7'b0010011};
      SLTI:  return {im[11:0], x.rs1, 3'd2, x.rd, 7'b0010011};
      ORI:   return {im[11:0], x.rs1, 3'd6, x.rd, 7'b0010011};
      ANDI:  return {im[11:0], x.rs1, 3'd7, x.rd, 7'b0010011};
      LW:    return {im[11:0], x.rs1, 3'd2, x.rd, 7'b0000011};
      JALR:  return {im[11:0], x.rs1, 3'd0, x.rd, 7'b1100111};
      SW:    return {im[11:5], x.rs2, x.rs1, 3'd2, im[4:0], 7'b0100011};
      BEQ:   return {im[12], im[10:5], x.rs2, x.rs1, 3'd0, im[4:1], im[11], 7'b1100011};
      BNE:   return {im[12], im[10:5], x.rs2, x.rs1, 3'd1, im[4:1], im[11], 7'b1100011};
      BLT:   return {im[12], im[10:5], x.rs2, x.rs1, 3'd4, im[4:1], im[11], 7'b1100011};
      LUI:   return {im[19:0], x.rd, 7'b0110111};
      AUIPC: return {im[19:0], x.rd, 7'b0010111};
      JAL:   return {im[20], im[10:1], im[11], im[19:12], x.rd, 7'b1101111};
      default: return 32'h0000007f;
    endcase
  endfunction

  // Reference model: executes one instruction record and queues any store it makes
  task automatic iss_step();
    ins_t x;
    logic [31:0] a, b, res, addr, nxt;
    logic wr;
    x = prog[m_pc[7:2]];
    a = m_regs[x.rs1];
    b = m_regs[x.rs2];
    nxt = m_pc + 4;
    res = 0;
    wr = 1'b1;
    addr = a + x.imm;
    case (x.op)
      ADD:   res = a + b;
      SUB:   res = a - b;
      AND:   res = a & b;
      OR:    res = a | b;
      XOR:   res = a ^ b;
      SLT:   res = ($signed(a) < $signed(b)) ? 1 : 0;
      SLL:   res = a << b[4:0];
      SRL:   res = a >> b[4:0];
      SRA:   res = $signed(a) >>> b[4:0];
      ADDI:  res = a + x.imm;
      ANDI:  res = a & x.imm;
      ORI:   res = a | x.imm;
      SLTI:  res = ($signed(a) < $signed(x.imm)) ? 1 : 0;
      LW:    res = m_ram[addr[7:2]];
      SW: begin
        wr = 1'b0;
        exp_q.push_back('{addr, b});
        m_ram[addr[7:2]] = b;
      end
      BEQ: begin wr = 1'b0; if (a == b) nxt = m_pc + x.imm; end
      BNE: begin wr = 1'b0; if (a != b) nxt = m_pc + x.imm; end
      BLT: begin wr = 1'b0; if ($signed(a) < $signed(b)) nxt = m_pc + x.imm; end
      LUI:   res = x.imm << 12;
      AUIPC: res = m_pc + (x.imm << 12);
      JAL:   begin res = m_pc + 4; nxt = m_pc + x.imm; end
      JALR:  begin res = m_pc + 4; nxt = addr & 32'hFFFF_FFFE; end
      default: wr = 1'b0;
    endcase
    if (wr && x.rd != 0) m_regs[x.rd] = res;
    m_pc = nxt;
  endtask

  task automatic clear_prog();
    for (int w = 0; w < 64; w++) prog[w] = '{JAL, 5'd0, 5'd0, 5'd0, 32'd0};
    plen = 0;
  endtask

  task automatic put(input kind_t op, input int rd, input int rs1, input int rs2, input int imm);
    prog[plen] = '{op, rd[4:0], rs1[4:0], rs2[4:0], imm};
    plen++;
  endtask

  // Loads ROM under reset, takes one reset edge, then runs n instructions
  task automatic run_prog(input int n, input int stop_early);
    for (int w = 0; w < 64; w++) dut.imem.ROM[w] = enc(prog[w]);
    @(posedge clk);
    @(negedge clk);
    check("we_during_reset", {31'd0, write_enable}, 32'd0);
    for (int r = 0; r < 32; r++) m_regs[r] = 0;
    m_pc = 0;
    for (int s = 0; s < n; s++) iss_step();
    @(posedge clk);
    #1 reset = 1'b0;
    repeat (n) @(posedge clk);
    #1 reset = 1'b1;
    if (stop_early == 0) check("store_queue_drained", exp_q.size(), 0);
    exp_q.delete();
  endtask

  always @(negedge clk) begin
    store_t e;
    if (!reset && write_enable) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_store: got addr %h data %h, expected no store", address_to_mem, data_to_mem);
      end else begin
        e = exp_q.pop_front();
        check("store_addr", address_to_mem, e.addr);
        check("store_data", data_to_mem, e.data);
      end
    end
  end

  task automatic build_jumps();
    clear_prog();
    put(LUI, 6, 0, 0, 32'h12345);
    put(SW, 0, 0, 6, 36);
    put(ADDI, 3, 0, 0, 0);
    put(ADDI, 0, 0, 0, 0);
    put(JAL, 1, 0, 0, 8);        // 0x10 -> 0x18, x1 = 0x14
    put(JAL, 0, 0, 0, 24);       // 0x14 -> 0x2c after jalr returns here
    put(SW, 0, 0, 1, 40);
    put(JAL, 0, 0, 0, 4);
    put(AUIPC, 7, 0, 0, 1);      // at 0x20
    put(SW, 0, 0, 7, 44);
    put(JALR, 0, 1, 0, 0);
    put(ADDI, 0, 0, 0, 7);
    put(SW, 0, 0, 0, 4);
    put(ADDI, 8, 0, 0, 32'h5a);
    put(SW, 0, 0, 8, 48);
    put(LW, 9, 0, 0, 48);
    put(SW, 0, 0, 9, 52);
  endtask

  task automatic build_random();
    int k, rd, r1, r2, im;
    clear_prog();
    for (int i = 0; i < 40; i++) begin
      k  = $urandom_range(0, 9);
      rd = $urandom_range(0, 7);
      r1 = $urandom_range(0, 7);
      r2 = $urandom_range(0, 7);
      im = int'($urandom_range(0, 4095)) - 2048;
      case (k)
        0, 1, 2: put(rops[$urandom_range(0, 8)], rd, r1, r2, 0);
        3, 4:    put(iops[$urandom_range(0, 3)], rd, r1, 0, im);
        5:       put(LUI, rd, 0, 0, int'($urandom_range(0, 20'hFFFFF)));
        6:       put(SW, 0, r1, r2, im);
        7:       put(LW, rd, r1, 0, im);
        8:       put(bops[$urandom_range(0, 2)], 0, r1, r2, ($urandom_range(0, 1) != 0) ? 8 : 12);
        default: put(($urandom_range(0, 1) != 0) ? AUIPC : BAD, rd, 0, 0, int'($urandom_range(0, 20'hFFFFF)));
      endcase
    end
    for (int r = 1; r < 8; r++) put(SW, 0, 0, r, 4 * (55 + r));
  endtask

  initial begin
    for (int w = 0; w < 64; w++) m_ram[w] = 0;

    // Clear RAM; word 0 is sw x0,0(x0) so reset must hold off its write
    clear_prog();
    put(SW, 0, 0, 0, 0);
    put(ADDI, 1, 0, 0, 4);
    put(ADDI, 2, 0, 0, 256);
    put(SW, 0, 1, 0, 0);
    put(ADDI, 1, 1, 0, 4);
    put(BNE, 0, 1, 2, -8);
    for (int w = 0; w < 64; w++) dut.imem.ROM[w] = enc(prog[w]);
    @(posedge clk);
    @(negedge clk);
    check("reset_addr", address_to_mem, 32'd0);
    check("reset_data", data_to_mem, 32'd0);
    run_prog(200, 0);

    clear_prog();
    put(ADDI, 1, 0, 0, 5);
    put(ADDI, 2, 0, 0, -3);
    put(ADD, 3, 1, 2, 0);
    put(SLT, 4, 2, 1, 0);
    put(SW, 0, 0, 3, 8);
    put(SW, 0, 0, 4, 12);
    put(SW, 0, 0, 1, 4);
    run_prog(10, 0);
    check("alu_ram2", dut.dmem.RAM[2], 32'h2);
    check("alu_ram3", dut.dmem.RAM[3], 32'h1);
    check("alu_ram1", dut.dmem.RAM[1], 32'h5);

    clear_prog();
    put(LUI, 1, 0, 0, 32'h80000);
    put(ADDI, 2, 0, 0, 4);
    put(SRA, 3, 1, 2, 0);
    put(SRL, 4, 1, 2, 0);
    put(SW, 0, 0, 3, 16);
    put(SW, 0, 0, 4, 20);
    put(XOR, 5, 3, 4, 0);
    put(SW, 0, 0, 5, 24);
    put(AND, 6, 3, 4, 0);
    put(OR, 7, 3, 2, 0);
    put(SW, 0, 0, 6, 28);
    put(SW, 0, 0, 7, 32);
    put(SLL, 8, 2, 2, 0);
    put(SUB, 9, 2, 1, 0);
    put(SW, 0, 0, 8, 36);
    put(SW, 0, 0, 9, 40);
    run_prog(20, 0);
    check("sra", dut.dmem.RAM[4], 32'hF800_0000);
    check("srl", dut.dmem.RAM[5], 32'h0800_0000);
    check("xor", dut.dmem.RAM[6], 32'hF000_0000);
    check("and", dut.dmem.RAM[7], 32'h0800_0000);
    check("or", dut.dmem.RAM[8], 32'hF800_0004);
    check("sll", dut.dmem.RAM[9], 32'h40);
    check("sub_wrap", dut.dmem.RAM[10], 32'h8000_0004);

    // Sum 1..10, then a not-taken beq whose target would skip the store
    clear_prog();
    put(ADDI, 5, 0, 0, 0);
    put(ADDI, 6, 0, 0, 1);
    put(ADDI, 7, 0, 0, 11);
    put(ADD, 5, 5, 6, 0);
    put(ADDI, 6, 6, 0, 1);
    put(BNE, 0, 6, 7, -8);
    put(BEQ, 0, 5, 0, 12);
    put(SW, 0, 0, 5, 0);
    put(BLT, 0, 0, 5, 8);
    put(JAL, 0, 0, 0, 0);
    put(SW, 0, 0, 6, 32);
    run_prog(50, 0);
    check("loop_sum", dut.dmem.RAM[0], 32'h37);
    check("blt_taken", dut.dmem.RAM[8], 32'hB);

    // Interrupt the jump program with reset after six instructions
    build_jumps();
    run_prog(6, 1);
    @(posedge clk);
    @(negedge clk);
    check("midreset_pc0_addr", address_to_mem, 32'h1234_5000);
    check("midreset_we", {31'd0, write_enable}, 32'd0);
    check("midreset_ram_kept", dut.dmem.RAM[2], 32'h2);
    run_prog(25, 0);
    check("lui", dut.dmem.RAM[9], 32'h1234_5000);
    check("jal_link", dut.dmem.RAM[10], 32'h14);
    check("auipc", dut.dmem.RAM[11], 32'h1020);
    check("x0_store", dut.dmem.RAM[1], 32'h0);
    check("lw_after_sw", dut.dmem.RAM[13], 32'h5a);

    for (int p = 0; p < 8; p++) begin
      build_random();
      run_prog(60, 0);
    end

    for (int w = 0; w < 64; w++) check($sformatf("ram_dump[%0d]", w), dut.dmem.RAM[w], m_ram[w]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
